// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding and constants for the UART receive frame controller.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DATA   = 3'd1,
      PARITY = 3'd2,
      STOP   = 3'd3,
      DONE   = 3'd4
   } rx_ctrl_state_t;

   localparam int UART_MAX_DATA_BITS = 9;
   localparam int UART_OVERSAMPLE    = 16;

endpackage

// File: rtl/uart_rx_timeout.sv
// rtl/uart_rx_timeout.sv - inter-strobe watchdog counting tick_16x periods while a frame is in flight.
module uart_rx_timeout #(
   parameter int BIT_TIMEOUT = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LAST_TICK = 8'(BIT_TIMEOUT - 1);

   logic [7:0] timeout_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_cnt <= '0;
      end else if (clear || !enable) begin
         timeout_cnt <= '0;
      end else if (tick) begin
         timeout_cnt <= timeout_cnt + 8'd1;
      end
   end

   // Fires on the tick that would bring the count to BIT_TIMEOUT.
   assign expired = enable && tick && (timeout_cnt == LAST_TICK);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame FSM, shift register and output handshake.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 1,
`ifdef UART_RX_PARITY_EN
   parameter int PARITY_ODD  = 0,
`endif
   parameter int BIT_TIMEOUT = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick_16x,
   input  logic                 start_detected,
   input  logic                 bit_valid,
   input  logic                 bit_sample,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 parity_err,
   output logic                 sampler_restart,
   output logic                 busy
);

   localparam int CNT_W = $clog2(UART_MAX_DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

   rx_ctrl_state_t       state, state_nxt;
   logic [DATA_BITS-1:0] shift_reg, shift_nxt;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
   logic                 stop_bad, stop_bad_nxt;
   logic [DATA_BITS-1:0] rx_data_nxt;
   logic                 rx_valid_nxt, frame_err_nxt, overrun_nxt, restart_nxt;
   logic                 parity_err_nxt, par_bad, par_bad_nxt;
   logic                 timeout_clear, timeout_en, timeout_expired;

   assign timeout_en = (state == DATA) || (state == PARITY) || (state == STOP);
   assign busy       = (state != IDLE);

   uart_rx_timeout #(.BIT_TIMEOUT(BIT_TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (timeout_clear),
      .tick    (tick_16x),
      .enable  (timeout_en),
      .expired (timeout_expired)
   );

   always_comb begin
      state_nxt      = state;
      shift_nxt      = shift_reg;
      bit_cnt_nxt    = bit_cnt;
      stop_bad_nxt   = stop_bad;
      par_bad_nxt    = par_bad;
      rx_data_nxt    = rx_data;
      rx_valid_nxt   = rx_valid && !rx_ready;
      frame_err_nxt  = 1'b0;
      overrun_nxt    = 1'b0;
      restart_nxt    = 1'b0;
      parity_err_nxt = 1'b0;
      timeout_clear  = bit_valid;
      case (state)
         IDLE: begin
            if (start_detected) begin
               state_nxt     = DATA;
               bit_cnt_nxt   = '0;
               stop_bad_nxt  = 1'b0;
               par_bad_nxt   = 1'b0;
               timeout_clear = 1'b1;
            end
         end
         DATA: begin
            if (bit_valid) begin
               shift_nxt = {bit_sample, shift_reg[DATA_BITS-1:1]};
               if (bit_cnt == LAST_DATA) begin
                  bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                  state_nxt   = PARITY;
`else
                  state_nxt   = STOP;
`endif
               end else begin
                  bit_cnt_nxt = bit_cnt + CNT_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bit_valid) begin
               par_bad_nxt = ((^shift_reg) ^ (PARITY_ODD != 0)) != bit_sample;
               state_nxt   = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_valid) begin
               if (!bit_sample) begin
                  stop_bad_nxt = 1'b1;
                  state_nxt    = DONE;
               end else if (bit_cnt == LAST_STOP) begin
                  state_nxt = DONE;
               end else begin
                  bit_cnt_nxt = bit_cnt + CNT_W'(1);
               end
            end
         end
         DONE: begin
            state_nxt   = IDLE;
            restart_nxt = 1'b1;
            if (stop_bad) begin
               frame_err_nxt = 1'b1;
            end else if (!rx_valid || rx_ready) begin
               rx_data_nxt    = shift_reg;
               rx_valid_nxt   = 1'b1;
               parity_err_nxt = par_bad;
            end else begin
               overrun_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A bit strobe on the terminal tick keeps the frame alive.
      if (timeout_expired && !bit_valid) begin
         state_nxt     = IDLE;
         frame_err_nxt = 1'b1;
         restart_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         shift_reg       <= '0;
         bit_cnt         <= '0;
         stop_bad        <= 1'b0;
         par_bad         <= 1'b0;
         rx_data         <= '0;
         rx_valid        <= 1'b0;
         frame_err       <= 1'b0;
         overrun_err     <= 1'b0;
         sampler_restart <= 1'b0;
      end else begin
         state           <= state_nxt;
         shift_reg       <= shift_nxt;
         bit_cnt         <= bit_cnt_nxt;
         stop_bad        <= stop_bad_nxt;
         par_bad         <= par_bad_nxt;
         rx_data         <= rx_data_nxt;
         rx_valid        <= rx_valid_nxt;
         frame_err       <= frame_err_nxt;
         overrun_err     <= overrun_nxt;
         sampler_restart <= restart_nxt;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= parity_err_nxt;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame-level controller for the UART receive path. It sits directly after the bit sampler and takes its start_detected, bit_valid and bit_sample strobes. It assembles DATA_BITS data bits LSB-first, checks the stop bit and hands the completed byte downstream on a valid/ready handshake. After every frame, or after an aborted frame, it pulses sampler_restart so the sampler returns to its idle/start-hunt state.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, stop bits checked per frame; 1 or 2.
BIT_TIMEOUT, 24, tick_16x periods allowed between consecutive sampler strobes before the frame is aborted; 17..255.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick_16x  in  1  16x oversampling tick, used only by the timeout counter
start_detected  in  1  1-cycle pulse from the sampler: valid start bit seen
bit_valid  in  1  1-cycle pulse from the sampler: bit_sample holds a data/parity/stop bit
bit_sample  in  1  sampled bit value, qualified by bit_valid
rx_ready  in  1  downstream accepts rx_data
rx_data  out  DATA_BITS  received byte, stable while rx_valid=1
rx_valid  out  1  byte available; held until rx_ready
frame_err  out  1  1-cycle pulse: bad stop bit or bit timeout
overrun_err  out  1  1-cycle pulse: frame completed while rx_valid still high
parity_err  out  1  1-cycle pulse (tied 0 without UART_RX_PARITY_EN)
sampler_restart  out  1  1-cycle pulse commanding the sampler back to IDLE
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, rx_data=0, state IDLE, bit_cnt=0, timeout_cnt=0. Reset is asynchronous; asserting it mid-frame discards the partial frame and any pending rx_valid.
- State encoding is 3 bits.
- IDLE:
  - start_detected -> DATA; clear bit_cnt and timeout_cnt.
  - bit_valid is ignored in IDLE.
- DATA:
  - Each bit_valid shifts bit_sample into the shift register LSB-first (first data bit ends in rx_data[0]) and increments bit_cnt.
  - After bit DATA_BITS-1 -> PARITY if the feature is enabled, otherwise -> STOP.
- PARITY: one bit_valid; compare against the configured parity, record the mismatch, -> STOP.
- STOP:
  - Each bit_valid checks bit_sample==1.
  - After STOP_BITS stop bits -> DONE.
  - A 0 stop bit -> DONE immediately with the error flagged.
- DONE (single cycle), outputs registered on the following edge:
  - Always pulses sampler_restart; -> IDLE.
  - Stop bit bad: frame_err=1, data dropped, rx_valid unchanged.
  - Stop good and rx_valid=0, or rx_valid=1 with rx_ready=1 in this same cycle: load rx_data, rx_valid=1; parity_err pulses alongside if the parity check failed.
  - Stop good and rx_valid=1 with rx_ready=0: overrun_err=1, new byte dropped, old rx_data kept.
- Latency: rx_valid rises 2 clk after the bit_valid of the final stop bit.
- Handshake: rx_valid clears on the edge where rx_valid and rx_ready are both 1. rx_data does not change while rx_valid=1.
- Timeout:
  - In DATA, PARITY or STOP, timeout_cnt increments on each tick_16x and clears on bit_valid.
  - When it reaches BIT_TIMEOUT: frame_err pulse, sampler_restart pulse, -> IDLE, data discarded.
  - If bit_valid and the terminal tick coincide, bit_valid wins.
- start_detected outside IDLE is ignored.
- Same-cycle start_detected and bit_valid in IDLE: start is taken, bit_valid dropped.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: adds parameter PARITY_ODD (default 0 = even parity) and the PARITY state. Parity is the XOR of the data bits, XOR PARITY_ODD. On mismatch, parity_err pulses in the same cycle rx_valid rises; the byte is still delivered.
- Undefined: no PARITY state, frame = start + DATA_BITS + STOP_BITS, parity_err tied to 0.

Decomposition:
- Package uart_rx_pkg holds: the rx_ctrl_state_t enum (IDLE, DATA, PARITY, STOP, DONE) and the constants UART_MAX_DATA_BITS=9 and UART_OVERSAMPLE=16.
- One sub-module, uart_rx_timeout, wraps timeout_cnt with inputs clear, tick and enable and output expired.
- The rest is one FSM plus the shift register.

Test Plan:
- Byte 0xA5, 8N1, rx_ready=1 → rx_data=0xA5 and rx_valid for 1 cycle, 2 clk after the stop-bit bit_valid; one sampler_restart pulse; no errors.
- Stop bit sampled 0 after data 0x3C → frame_err pulse, rx_valid stays 0, sampler_restart pulse, busy=0 the next cycle.
- Two frames 0x11 then 0x22 with rx_ready=0 → rx_valid=1 with rx_data=0x11; overrun_err pulse at the end of frame 2; rx_data remains 0x11 until rx_ready.
- rx_ready asserted in the DONE cycle of frame 0x22 while 0x11 is pending → 0x11 consumed, 0x22 loaded, no overrun_err.
- After 3 data bits, no bit_valid for 24 tick_16x → frame_err pulse and sampler_restart pulse, state IDLE; a subsequent frame 0x5A is received correctly.
- Build with UART_RX_PARITY_EN and PARITY_ODD=0: 0x07 with parity bit 0 → rx_valid together with parity_err=1, rx_data=0x07; with parity bit 1 → no parity_err.
